vga_timing_gen: RTL
===================

# vga_timing_gen

Generates 640×480@60 VGA raster timing from the 50 MHz board clock. Outputs are a pixel strobe, registered sync pulses, a data-enable flag and the current raster coordinates. Sits directly upstream of the scaled pixel generator in the top-level VGA path. That generator samples `sx`/`sy`/`de` on `pix_stb` and forwards `hsync`/`vsync` to the `vga_out_hs`/`vga_out_vs` pins.

## Interface
Parameters:
- `CORDW`, 10, coordinate width; must hold `H_TOTAL-1` and `V_TOTAL-1`
- `CLK_DIV`, 2, system clocks per pixel, ≥1 (50 MHz / 2 = 25 MHz pixel rate)
- `H_RES`, 640; `H_FP`, 16; `H_SYNC`, 96; `H_BP`, 48, horizontal active / front porch / sync / back porch in pixels
- `V_RES`, 480; `V_FP`, 10; `V_SYNC`, 2; `V_BP`, 33, vertical equivalents in lines
- `H_POL`, 0, hsync level while asserted (0 = active-low)
- `V_POL`, 0, vsync level while asserted

Derived values: `H_TOTAL = H_RES+H_FP+H_SYNC+H_BP` (800) and `V_TOTAL = V_RES+V_FP+V_SYNC+V_BP` (525).

Ports:
- `clk`  in  1  system clock, 50 MHz
- `rst_n`  in  1  asynchronous active-low reset
- `pix_stb`  out  1  pixel enable; high one clk every `CLK_DIV` clks
- `sx`  out  CORDW  horizontal position, 0..H_TOTAL-1
- `sy`  out  CORDW  vertical position, 0..V_TOTAL-1
- `de`  out  1  high while `sx<H_RES && sy<V_RES`
- `hsync`  out  1  horizontal sync, polarity set by `H_POL`
- `vsync`  out  1  vertical sync, polarity set by `V_POL`
- `line_start`  out  1  one-clk pulse in the first clk of each `sx==0`
- `frame_start`  out  1  one-clk pulse in the first clk of `sx==0 && sy==0`
- `frame_cnt`  out  16  frame counter; present only with `VGA_TIMING_FRAME_CNT_EN`

## Operation
- Divider: `div_cnt` counts 0..CLK_DIV-1 and wraps.
  - `pix_stb = (div_cnt == CLK_DIV-1)`.
  - With `CLK_DIV==1`, `pix_stb` is constant 1 once out of reset.
- On each clk edge where `pix_stb` is high:
  - If `sx == H_TOTAL-1`: `sx` becomes 0. Then `sy` becomes 0 if `sy == V_TOTAL-1`, else `sy+1`.
  - Otherwise `sx` becomes `sx+1`.
- `hsync`, `vsync`, `de`, `line_start` and `frame_start` are registered from the next `sx`/`sy` values, so they change on the same edge as the coordinates they describe. There is no skew between them.
- Sync windows, using default parameters:
  - `hsync` is asserted for `H_RES+H_FP ≤ sx < H_RES+H_FP+H_SYNC`, i.e. 656..751.
  - `vsync` is asserted for `V_RES+V_FP ≤ sy < V_RES+V_FP+V_SYNC`, i.e. 490..491.
  - The vsync window spans whole lines and switches at `sx==0`.
- Arithmetic: all comparisons are unsigned at width `CORDW`. Counters never exceed `TOTAL-1`; there is no overflow path.
- The block runs freely; there is no stall or ready input.

## Timing
- Reset values, asserted asynchronously:
  - `div_cnt=0`, `pix_stb=0`
  - `sx=H_TOTAL-1`, `sy=V_TOTAL-1`
  - `de=0`, `line_start=0`, `frame_start=0`
  - `hsync=~H_POL`, `vsync=~V_POL` (both inactive)
- After `rst_n` deasserts, with `CLK_DIV=2`:
  - Clk 0: `pix_stb=0`.
  - Clk 1: `pix_stb=1`.
  - Clk 2: `sx=0`, `sy=0`, `de=1`, `line_start=1`, `frame_start=1`.
  - The first pixel of the first frame is always the full pixel (0,0).
- `line_start`/`frame_start` are high for exactly one clk, regardless of `CLK_DIV`.
- Each coordinate holds for `CLK_DIV` clks. Line period is `H_TOTAL*CLK_DIV` clks (1600). Frame period is 840000 clks.
- Reset mid-frame: all outputs return to their reset values immediately. Timing restarts from the same sequence as power-up; no partial line is emitted after release.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN` defined: the `frame_cnt` port exists.
  - Reset value is 16'hFFFF.
  - It increments on the same edge that raises `frame_start`, so the first frame reads 0.
  - It wraps from 16'hFFFF to 0.
- Not defined: the port and its register are absent. All other behaviour is identical.

## Test plan
- Reset check: hold `rst_n=0` → `sx=799`, `sy=524`, `de=0`, `hsync=1`, `vsync=1`, `pix_stb=0`. Release → `frame_start=1` at clk 2 with `sx=0`, `sy=0`, `de=1`.
- Horizontal line: `hsync` is low for exactly 192 clks, from `sx=656` through `sx=751`. `de` is high for 1280 clks per active line. `line_start` spacing is 1600 clks.
- Vertical frame: `vsync` is low exactly while `sy` is 490..491, i.e. 3200 clks. `frame_start` spacing is 840000 clks. `de` is never high while `sy≥480`.
- Mid-frame reset: pulse `rst_n` low for 3 clks at `sx=300`, `sy=200` → outputs take reset values during the pulse, and the post-release sequence matches the power-up check.
- `CLK_DIV=1` build: `pix_stb` is constantly 1 after reset. `sx` advances every clk. Frame period is 420000 clks.
- `VGA_TIMING_FRAME_CNT_EN` build: `frame_cnt` reads 0 in the first frame and 1 in the second. Force the counter to 16'hFFFF, and the next `frame_start` → `frame_cnt=0`.

Source files
------------

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel strobe, sync pulses, data enable and coordinates.
// Optional 16-bit frame counter port enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int CORDW   = 10,
  parameter int CLK_DIV = 2,
  parameter int H_RES   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_RES   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter bit H_POL   = 1'b0,
  parameter bit V_POL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             pix_stb,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             de,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
  localparam int DIVW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIVW-1:0]  DIV_MAX   = DIVW'(CLK_DIV - 1);
  localparam logic [CORDW-1:0] H_MAX     = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_MAX     = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACT_END = CORDW'(H_RES);
  localparam logic [CORDW-1:0] V_ACT_END = CORDW'(V_RES);
  localparam logic [CORDW-1:0] HS_BEG    = CORDW'(H_RES + H_FP);
  localparam logic [CORDW-1:0] HS_END    = CORDW'(H_RES + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] VS_BEG    = CORDW'(V_RES + V_FP);
  localparam logic [CORDW-1:0] VS_END    = CORDW'(V_RES + V_FP + V_SYNC);

  logic [DIVW-1:0]  div_cnt;
  logic [CORDW-1:0] sx_next;
  logic [CORDW-1:0] sy_next;
  logic             de_next;
  logic             hs_act_next;
  logic             vs_act_next;
  logic             frame_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_MAX) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Gated by rst_n so the strobe reads 0 in reset even when CLK_DIV==1.
  assign pix_stb = rst_n & (div_cnt == DIV_MAX);

  always_comb begin
    sx_next = sx + 1'b1;
    sy_next = sy;
    if (sx == H_MAX) begin
      sx_next = '0;
      sy_next = (sy == V_MAX) ? '0 : sy + 1'b1;
    end
  end

  assign de_next     = (sx_next < H_ACT_END) && (sy_next < V_ACT_END);
  assign hs_act_next = (sx_next >= HS_BEG) && (sx_next < HS_END);
  assign vs_act_next = (sy_next >= VS_BEG) && (sy_next < VS_END);
  assign frame_next  = (sx_next == '0) && (sy_next == '0);

  // Flags are registered from the next coordinates so they move with sx/sy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx          <= H_MAX;
      sy          <= V_MAX;
      de          <= 1'b0;
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_stb) begin
      sx          <= sx_next;
      sy          <= sy_next;
      de          <= de_next;
      hsync       <= hs_act_next ? H_POL : ~H_POL;
      vsync       <= vs_act_next ? V_POL : ~V_POL;
      line_start  <= (sx_next == '0);
      frame_start <= frame_next;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Starts at all-ones so the first frame after reset reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= 16'hFFFF;
    end else if (pix_stb && frame_next) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`else
  // No frame counter in this build.
`endif

endmodule
